// File: rtl/demodulate_multi_channel.sv
// demodulate_multi_channel
//   Multi-channel FM demodulator front end. For each time-interleaved complex
//   stream it forms the conjugate product of the current and previous sample
//   of the same channel and dequantises it:
//     real = (prev_r*x_r + prev_i*x_i) / 2^FRAC_BITS
//     imag = (prev_r*x_i - prev_i*x_r) / 2^FRAC_BITS   (truncated toward zero)
//   Three-stage pipeline: S1 capture, S2 multiply, S3 sum/dequantise/output.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   clear                 sync pulse: zero prev-sample state, channel index to 0
//   inA_*                 real-part input FIFO (rd_en / empty / dout)
//   inB_*                 imag-part input FIFO (rd_en / empty / dout)
//   out_real_*            real-result output FIFO (wr_en / full / din)
//   out_imag_*            imag-result output FIFO (wr_en / full / din)
//   out_ch                channel tag of the result on out_*_din
//   busy                  any pipeline stage holds a valid sample
module demodulate_multi_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int NUM_CH     = 1,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  inA_rd_en,
  input  logic                  inA_empty,
  input  logic [DATA_WIDTH-1:0] inA_dout,
  output logic                  inB_rd_en,
  input  logic                  inB_empty,
  input  logic [DATA_WIDTH-1:0] inB_dout,
  output logic                  out_real_wr_en,
  input  logic                  out_real_full,
  output logic [DATA_WIDTH-1:0] out_real_din,
  output logic                  out_imag_wr_en,
  input  logic                  out_imag_full,
  output logic [DATA_WIDTH-1:0] out_imag_din,
  output logic [CH_W-1:0]       out_ch,
  output logic                  busy
);

  typedef logic signed [DATA_WIDTH-1:0]   data_t;
  typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
  typedef logic signed [2*DATA_WIDTH:0]   sum_t;

  // Added to negative sums before the arithmetic shift so the division
  // truncates toward zero instead of toward minus infinity.
  localparam sum_t DQ_BIAS  = (sum_t'(1) <<< FRAC_BITS) - sum_t'(1);
  localparam sum_t SUM_ZERO = '0;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic            advance;
  logic            pop;
  logic            push;

  logic [CH_W-1:0] ch;
  data_t           prev_r [NUM_CH];
  data_t           prev_i [NUM_CH];

  logic            s1_valid;
  data_t           s1_xr, s1_xi, s1_pr, s1_pi;
  logic [CH_W-1:0] s1_ch;

  logic            s2_valid;
  prod_t           s2_rr, s2_ii, s2_ri, s2_ir;
  logic [CH_W-1:0] s2_ch;

  logic            s3_valid;
  data_t           s3_real, s3_imag;
  logic [CH_W-1:0] s3_ch;

  sum_t            sum_r, sum_i;
  data_t           deq_r, deq_i;

  // The whole pipeline moves as one; a blocked output freezes every stage.
  assign advance = !s3_valid || push;
  // Gated by reset so nothing is popped while the block is held in reset.
  assign pop     = reset && !inA_empty && !inB_empty && advance && !clear;
  assign push    = s3_valid && !out_real_full && !out_imag_full;

  assign inA_rd_en      = pop;
  assign inB_rd_en      = pop;
  assign out_real_wr_en = push;
  assign out_imag_wr_en = push;
  assign out_real_din   = s3_real;
  assign out_imag_din   = s3_imag;
  assign out_ch         = s3_ch;
  assign busy           = s1_valid || s2_valid || s3_valid;

  // Per-channel previous sample and round-robin channel index. The S1
  // capture reads prev[ch] on the same edge that overwrites it, so a
  // single-channel stream needs no bubble between samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        prev_r[k] <= '0;
        prev_i[k] <= '0;
      end
    end else if (clear) begin
      ch <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        prev_r[k] <= '0;
        prev_i[k] <= '0;
      end
    end else if (pop) begin
      prev_r[ch] <= data_t'(inA_dout);
      prev_i[ch] <= data_t'(inB_dout);
      ch         <= (ch == LAST_CH) ? '0 : ch + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_xr    <= '0;
      s1_xi    <= '0;
      s1_pr    <= '0;
      s1_pi    <= '0;
      s1_ch    <= '0;
    end else if (advance) begin
      s1_valid <= pop;
      if (pop) begin
        s1_xr <= data_t'(inA_dout);
        s1_xi <= data_t'(inB_dout);
        s1_pr <= prev_r[ch];
        s1_pi <= prev_i[ch];
        s1_ch <= ch;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
      s2_ch    <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rr <= prod_t'(s1_pr) * prod_t'(s1_xr);
        s2_ii <= prod_t'(s1_pi) * prod_t'(s1_xi);
        s2_ri <= prod_t'(s1_pr) * prod_t'(s1_xi);
        s2_ir <= prod_t'(s1_pi) * prod_t'(s1_xr);
        s2_ch <= s1_ch;
      end
    end
  end

  // Sums carry one extra bit so they cannot overflow; the dequantised result
  // keeps only the low DATA_WIDTH bits (wraps, no saturation).
  always_comb begin
    sum_r = sum_t'(s2_rr) + sum_t'(s2_ii);
    sum_i = sum_t'(s2_ri) - sum_t'(s2_ir);
    deq_r = data_t'((sum_r + (sum_r[2*DATA_WIDTH] ? DQ_BIAS : SUM_ZERO)) >>> FRAC_BITS);
    deq_i = data_t'((sum_i + (sum_i[2*DATA_WIDTH] ? DQ_BIAS : SUM_ZERO)) >>> FRAC_BITS);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s3_valid <= 1'b0;
      s3_real  <= '0;
      s3_imag  <= '0;
      s3_ch    <= '0;
    end else if (advance) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_real <= deq_r;
        s3_imag <= deq_i;
        s3_ch   <= s2_ch;
      end
    end
  end

endmodule

// File: tb/tb_demodulate_multi_channel.sv
// tb_demodulate_multi_channel
//   Directed bench for demodulate_multi_channel with two interleaved channels.
//   Input FIFOs are modelled as arrays with a read pointer; every write is
//   recorded by a negedge monitor and compared against hand-computed values
//   or a small reference model of the conjugate-product demodulator.
module tb_demodulate_multi_channel;
  localparam int DW  = 32;
  localparam int FB  = 10;
  localparam int NCH = 2;
  localparam int CW  = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          inA_rd_en, inA_empty, inB_rd_en, inB_empty;
  logic [DW-1:0] inA_dout, inB_dout;
  logic          out_real_wr_en, out_imag_wr_en;
  logic          out_real_full = 1'b0;
  logic          out_imag_full = 1'b0;
  logic [DW-1:0] out_real_din, out_imag_din;
  logic [CW-1:0] out_ch;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] vr [64];
  logic [DW-1:0] vi [64];
  int n_in = 0, rd_idx = 0, n_out = 0, n_exp = 0, cyc = 0, cmp_idx = 0;
  int rd_cyc [64];
  int wr_cyc [64];
  logic [DW-1:0] got_r [64], got_i [64], exp_r [64], exp_i [64];
  logic [CW-1:0] got_ch [64], exp_ch [64];
  longint m_pr [NCH];
  longint m_pi [NCH];
  int     m_ch = 0;

  demodulate_multi_channel #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_CH(NCH), .CH_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .inA_rd_en(inA_rd_en), .inA_empty(inA_empty), .inA_dout(inA_dout),
    .inB_rd_en(inB_rd_en), .inB_empty(inB_empty), .inB_dout(inB_dout),
    .out_real_wr_en(out_real_wr_en), .out_real_full(out_real_full), .out_real_din(out_real_din),
    .out_imag_wr_en(out_imag_wr_en), .out_imag_full(out_imag_full), .out_imag_din(out_imag_din),
    .out_ch(out_ch), .busy(busy)
  );

  always #5 clock = ~clock;

  assign inA_empty = (rd_idx >= n_in);
  assign inB_empty = (rd_idx >= n_in);
  assign inA_dout  = vr[rd_idx[5:0]];
  assign inB_dout  = vi[rd_idx[5:0]];

  // FIFO read pointer and cycle counter advance on the active edge.
  initial begin
    forever begin
      @(posedge clock);
      cyc <= cyc + 1;
      if (inA_rd_en) rd_idx <= rd_idx + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      check_val("rd_pair", 64'(inB_rd_en), 64'(inA_rd_en));
      check_val("wr_pair", 64'(out_imag_wr_en), 64'(out_real_wr_en));
      if (inA_rd_en) rd_cyc[rd_idx[5:0]] = cyc;
      if (out_real_wr_en) begin
        got_r[n_out[5:0]]  = out_real_din;
        got_i[n_out[5:0]]  = out_imag_din;
        got_ch[n_out[5:0]] = out_ch;
        wr_cyc[n_out[5:0]] = cyc;
        n_out++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_raw(input logic [DW-1:0] r, input logic [DW-1:0] i);
    vr[n_in[5:0]] = r;
    vi[n_in[5:0]] = i;
    n_in++;
  endtask

  task automatic push_exp(input logic [DW-1:0] r, input logic [DW-1:0] i,
                          input logic [DW-1:0] er, input logic [DW-1:0] ei, input logic [CW-1:0] ech);
    push_raw(r, i);
    exp_r[n_exp[5:0]]  = er;
    exp_i[n_exp[5:0]]  = ei;
    exp_ch[n_exp[5:0]] = ech;
    n_exp++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_pr[k] = 0;
      m_pi[k] = 0;
    end
    m_ch = 0;
  endtask

  // Reference: integer division truncates toward zero, then wrap to DW bits.
  function automatic logic [DW-1:0] deq(input longint v);
    return DW'(v / 1024);
  endfunction

  task automatic model_push(input longint r, input longint i);
    longint pr, pi;
    pr = m_pr[m_ch];
    pi = m_pi[m_ch];
    push_exp(DW'(r), DW'(i), deq(pr * r + pi * i), deq(pr * i - pi * r), CW'(m_ch));
    m_pr[m_ch] = r;
    m_pi[m_ch] = i;
    m_ch = (m_ch == NCH - 1) ? 0 : m_ch + 1;
  endtask

  task automatic wait_popped();
    for (int k = 0; k < 100 && rd_idx < n_in; k++) tick();
    check_val("pop_wait", 64'(rd_idx), 64'(n_in));
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && !(n_out == n_exp && !busy); k++) tick();
    check_val("drain_count", 64'(n_out), 64'(n_exp));
    check_val("drain_busy", 64'(busy), 64'(0));
    while (cmp_idx < n_out && cmp_idx < n_exp) begin
      check_val($sformatf("out%0d_real", cmp_idx), 64'(got_r[cmp_idx[5:0]]), 64'(exp_r[cmp_idx[5:0]]));
      check_val($sformatf("out%0d_imag", cmp_idx), 64'(got_i[cmp_idx[5:0]]), 64'(exp_i[cmp_idx[5:0]]));
      check_val($sformatf("out%0d_ch", cmp_idx), 64'(got_ch[cmp_idx[5:0]]), 64'(exp_ch[cmp_idx[5:0]]));
      cmp_idx++;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] held_r, held_i;
    logic [CW-1:0] held_ch;
    int base;

    // Reset state
    #2 reset = 1'b0;
    #3;
    check_val("rst_rd_en", 64'(inA_rd_en), 64'(0));
    check_val("rst_wr_en", 64'(out_real_wr_en), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_real", 64'(out_real_din), 64'(0));
    check_val("rst_imag", 64'(out_imag_din), 64'(0));
    check_val("rst_ch", 64'(out_ch), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Two interleaved channels, back-to-back, plus 3-cycle latency
    push_exp(32'd1024, 32'd0,   32'd0,    32'd0, 1'b0);
    push_exp(32'd512,  32'd0,   32'd0,    32'd0, 1'b1);
    push_exp(32'd1024, 32'd0,   32'd1024, 32'd0, 1'b0);
    push_exp(32'd0,    32'd512, 32'd0,    32'd256, 1'b1);
    wait_drain();
    for (int k = 0; k < 4; k++)
      check_val($sformatf("latency%0d", k), 64'(wr_cyc[k] - rd_cyc[k]), 64'(3));

    // Isolated samples with bubbles; truncation toward zero on negatives
    push_exp(32'd0,          32'd1024, 32'd0, 32'd1024,     1'b0);
    tick(); tick(); tick();
    push_exp(32'd3,          32'd0,    32'd0, 32'hFFFFFFFF, 1'b1);
    tick(); tick(); tick(); tick(); tick();
    push_exp(32'd3,          32'd0,    32'd0, 32'hFFFFFFFD, 1'b0);
    tick(); tick();
    push_exp(32'hFFFFFFFB,   32'd0,    32'd0, 32'd0,        1'b1);
    wait_drain();

    // Large operands: result wraps to the low 32 bits
    push_exp(32'h40000000, 32'd0, 32'd3145728,   32'd0, 1'b0);
    push_exp(32'd0,        32'd0, 32'd0,         32'd0, 1'b1);
    push_exp(32'h40000400, 32'd0, 32'h40000000,  32'd0, 1'b0);
    push_exp(32'd7,        32'd0, 32'd0,         32'd0, 1'b1);
    wait_drain();

    // 20-sample stream with a 5-cycle output stall
    pulse_clear();
    model_reset();
    base = rd_idx;
    for (int k = 0; k < 20; k++)
      model_push(longint'($urandom_range(0, 8191)) - 4096, longint'($urandom_range(0, 8191)) - 4096);
    for (int k = 0; k < 50 && rd_idx < base + 8; k++) tick();
    check_val("pre_stall_wr", 64'(out_real_wr_en), 64'(1));
    out_real_full = 1'b1;
    #1;
    held_r  = out_real_din;
    held_i  = out_imag_din;
    held_ch = out_ch;
    check_val("stall_rd_en", 64'(inA_rd_en), 64'(0));
    check_val("stall_wr_en", 64'(out_imag_wr_en), 64'(0));
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val($sformatf("stall%0d_rd_en", k), 64'(inA_rd_en), 64'(0));
      check_val($sformatf("stall%0d_real", k), 64'(out_real_din), 64'(held_r));
      check_val($sformatf("stall%0d_imag", k), 64'(out_imag_din), 64'(held_i));
      check_val($sformatf("stall%0d_ch", k), 64'(out_ch), 64'(held_ch));
    end
    out_real_full = 1'b0;
    wait_drain();

    // clear with samples in flight: they complete, then prev and ch restart
    model_push(100, 200);
    model_push(300, -400);
    model_push(-500, 600);
    model_push(700, 800);
    wait_popped();
    clear = 1'b1;
    model_reset();
    model_push(1024, 0);
    #1;
    check_val("clear_rd_en", 64'(inA_rd_en), 64'(0));
    tick();
    clear = 1'b0;
    model_push(0, 1024);
    model_push(0, 1024);
    wait_drain();

    // Reset with two samples in flight and one waiting in the FIFO
    push_raw(32'd11, 32'd22);
    push_raw(32'd33, 32'd44);
    wait_popped();
    model_reset();
    model_push(1024, 512);
    reset = 1'b0;
    #1;
    check_val("mid_rst_rd_en", 64'(inA_rd_en), 64'(0));
    check_val("mid_rst_wr_en", 64'(out_real_wr_en), 64'(0));
    check_val("mid_rst_busy", 64'(busy), 64'(0));
    check_val("mid_rst_real", 64'(out_real_din), 64'(0));
    check_val("mid_rst_ch", 64'(out_ch), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    model_push(0, 1024);
    model_push(2048, 0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demodulate_multi_channel.md
Name: demodulate_multi_channel

Overview:
- Parametrised successor to the two-input FM demodulator.
- For each interleaved complex stream it computes the conjugate product of the current and previous sample: real = prev_r*x_r + prev_i*x_i and imag = prev_r*x_i - prev_i*x_r, each dequantised.
- Supports NUM_CH time-interleaved channels, each with its own previous-sample state, and tags every output with its channel.
- Sits between the I/Q input FIFOs and the arctan/gain stage of the FM radio chain; all I/O uses FIFO-style handshakes.

Parameters:
DATA_WIDTH, 32, sample width (signed two's complement), inputs and outputs
FRAC_BITS, 10, dequantise shift; result divided by 2^FRAC_BITS
NUM_CH, 1, interleaved channel count (1..16)
CH_W, $clog2(NUM_CH) min 1, width of channel tag

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  sync pulse: zero all prev-sample state, channel index to 0
inA_rd_en  out  1  pop real-part input FIFO
inA_empty  in  1  real-part FIFO empty
inA_dout  in  DATA_WIDTH  real-part sample
inB_rd_en  out  1  pop imag-part input FIFO
inB_empty  in  1  imag-part FIFO empty
inB_dout  in  DATA_WIDTH  imag-part sample
out_real_wr_en  out  1  push real result
out_real_full  in  1  real output FIFO full
out_real_din  out  DATA_WIDTH  real result
out_imag_wr_en  out  1  push imag result
out_imag_full  in  1  imag output FIFO full
out_imag_din  out  DATA_WIDTH  imag result
out_ch  out  CH_W  channel tag of the current output
busy  out  1  any pipeline stage valid

Behaviour:
- Reset (reset=0, async):
  - All valid bits, prev_r/prev_i[0..NUM_CH-1], channel index and output data/out_ch are cleared to 0.
  - inA_rd_en, inB_rd_en, out_real_wr_en, out_imag_wr_en and busy are 0.
- Pipeline S1 (capture) -> S2 (multiply) -> S3 (sum/dequantise/output). Each stage has a valid bit.
- advance = !s3_valid || (out_real_wr_en); all stages shift only when advance=1.
- inA_rd_en = inB_rd_en = !inA_empty && !inB_empty && advance && !clear. Both inputs are always popped together; a single-FIFO pop never occurs.
- S1 capture on rd_en:
  - Register x_r = inA_dout, x_i = inB_dout, p_r/p_i = prev[ch] and tag = ch.
  - In the same edge, write prev[ch] <= (x_r, x_i).
  - ch <= (ch == NUM_CH-1) ? 0 : ch+1.
  - Back-to-back samples on one channel (NUM_CH=1) see the correct prev; no bubble is required.
- S2: four signed products of 2*DATA_WIDTH bits each.
- S3 arithmetic:
  - Compute the real and imag sums in 2*DATA_WIDTH+1 bits.
  - Dequantise by dividing by 2^FRAC_BITS, truncating toward zero. For negative values add 2^FRAC_BITS-1 before the arithmetic shift.
  - Keep the low DATA_WIDTH bits (wrap, no saturation).
- Output:
  - out_real_wr_en = out_imag_wr_en = s3_valid && !out_real_full && !out_imag_full. Both outputs are written in the same cycle; never one alone.
  - din and out_ch hold stable while s3_valid and blocked.
- Latency: 3 cycles from rd_en to wr_en with no backpressure. Throughput is 1 sample/cycle.
- Stall: if either output is full while s3_valid, the whole pipeline freezes and rd_en=0. No sample is dropped or duplicated, and order is preserved.
- First sample per channel after reset or clear uses prev=(0,0), so its output is (0,0).
- clear:
  - Takes effect at the next edge: prev all zero, ch=0.
  - rd_en is forced 0 in the clear cycle.
  - In-flight samples complete with their already-captured operands.
  - clear during a stall does not unfreeze the pipeline.
- Input empty mid-stream: bubbles propagate and the output simply skips cycles; busy=0 when all stages are invalid.

Test Plan:
- NUM_CH=1, FRAC_BITS=10, inputs (1024,0),(0,1024) -> outputs (0,0) then (0,1024); wr_en exactly 3 cycles after each rd_en.
- NUM_CH=1, inputs (3,0),(-5,0) -> second real = -15/1024 = 0 (toward zero, not -1); imag 0.
- NUM_CH=2, inputs A(1024,0), B(512,0), A(1024,0), B(0,512) -> (0,0,ch0), (0,0,ch1), (1024,0,ch0), (0,256,ch1).
- Stream of 20 samples with out_real_full held high 5 cycles mid-stream -> rd_en low during stall, outputs held stable, all 20 results in order and equal to the software model (C demodulate cmp files).
- After 4 samples assert clear one cycle, then input (1024,0) -> inputs in flight finish unchanged; next output (0,0) with out_ch=0.
- Drop reset mid-stream with 2 samples in flight -> all wr_en/rd_en 0 immediately, busy=0; after release the first output is (0,0).
